// File: rtl/md_unit_param.sv
// -----------------------------------------------------------------------------
// md_unit_param
//   Multi-cycle multiply/divide unit for the pipelined MIPS core (E stage).
//   Owns the HI/LO registers. A multiply or divide result is computed when the
//   operation issues and is parked in pending registers. A down-counter then
//   holds the unit busy for MULT_CYCLES or DIV_CYCLES before HI/LO are updated.
//
//   Optional feature: define MD_MADD_EN to enable MADD/MADDU (ops 6/7).
//   When it is undefined, ops 6/7 are no-ops.
//
// Parameters
//   WIDTH        operand and HI/LO width
//   MULT_CYCLES  busy cycles for mult/multu/madd/maddu (1..255)
//   DIV_CYCLES   busy cycles for div/divu (1..255)
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   start   in   issue op this cycle (ignored while busy)
//   op      in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU
//   a, b    in   rs / rt operands
//   cancel  in   abort the in-flight op; also blocks issue this cycle
//   busy    out  operation in flight
//   done    out  one-cycle pulse when HI/LO take a multi-cycle result
//   hi, lo  out  HI / LO registers
// -----------------------------------------------------------------------------
module md_unit_param #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MADDU = 3'd7
    } op_e;

    localparam logic [7:0]       MULT_CNT = 8'(MULT_CYCLES);
    localparam logic [7:0]       DIV_CNT  = 8'(DIV_CYCLES);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0]   pend_lo_q, pend_lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // ------------------------------------------------------------------
    // Arithmetic datapath (evaluated on the issue cycle only)
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   b_nz;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   mag_q, mag_r;
    logic [WIDTH-1:0]   div_s_q, div_s_r;
    logic [WIDTH-1:0]   div_u_q, div_u_r;
`ifdef MD_MADD_EN
    logic [2*WIDTH-1:0] madd_s, madd_u;
`endif

    always_comb begin
        // Low 2*WIDTH bits of the product of sign-extended operands are the
        // exact signed product.
        prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

        // Divisor forced nonzero so the divider never sees 0; the zero case
        // is substituted below.
        b_nz = (b == '0) ? ONE : b;

        // Signed divide via magnitudes: quotient negated when signs differ,
        // remainder follows the dividend's sign (truncation toward zero).
        a_mag = a[WIDTH-1]    ? (WIDTH'(0) - a)    : a;
        b_mag = b_nz[WIDTH-1] ? (WIDTH'(0) - b_nz) : b_nz;
        mag_q = a_mag / b_mag;
        mag_r = a_mag % b_mag;

        if (b == '0) begin
            div_s_q = '1;
            div_s_r = a;
        end else if (a == MOST_NEG && b == '1) begin
            div_s_q = a;
            div_s_r = '0;
        end else begin
            div_s_q = (a[WIDTH-1] ^ b[WIDTH-1]) ? (WIDTH'(0) - mag_q) : mag_q;
            div_s_r = a[WIDTH-1] ? (WIDTH'(0) - mag_r) : mag_r;
        end

        if (b == '0) begin
            div_u_q = '1;
            div_u_r = a;
        end else begin
            div_u_q = a / b_nz;
            div_u_r = a % b_nz;
        end

`ifdef MD_MADD_EN
        // Accumulate onto HI/LO as they stand at issue; wraps modulo 2^(2*WIDTH).
        madd_s = {hi_q, lo_q} + prod_s;
        madd_u = {hi_q, lo_q} + prod_u;
`endif
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                // cancel blocks issue of every op, including MTHI/MTLO.
                if (start && !cancel) begin
                    case (op)
                        OP_MULT: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            cnt_d   = MULT_CNT;
                            state_d = S_RUN;
                            busy_d  = 1'b1;
                        end
                        OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            cnt_d   = MULT_CNT;
                            state_d = S_RUN;
                            busy_d  = 1'b1;
                        end
                        OP_DIV: begin
                            pend_hi_d = div_s_r;
                            pend_lo_d = div_s_q;
                            cnt_d     = DIV_CNT;
                            state_d   = S_RUN;
                            busy_d    = 1'b1;
                        end
                        OP_DIVU: begin
                            pend_hi_d = div_u_r;
                            pend_lo_d = div_u_q;
                            cnt_d     = DIV_CNT;
                            state_d   = S_RUN;
                            busy_d    = 1'b1;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
`ifdef MD_MADD_EN
                        OP_MADD: begin
                            {pend_hi_d, pend_lo_d} = madd_s;
                            cnt_d   = MULT_CNT;
                            state_d = S_RUN;
                            busy_d  = 1'b1;
                        end
                        OP_MADDU: begin
                            {pend_hi_d, pend_lo_d} = madd_u;
                            cnt_d   = MULT_CNT;
                            state_d = S_RUN;
                            busy_d  = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
            end

            S_RUN: begin
                // start is ignored here; cancel beats the completing edge.
                if (cancel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == 8'd1) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit_param.sv
module tb_md_unit_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cancel;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    md_unit_param #(
        .WIDTH      (32),
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .cancel(cancel),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          busy_n;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Presents op for one edge; returns at the negedge of busy cycle 1.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n = 0;
        logic early_done = 1'b0;
        issue(v.op, v.a, v.b);
        while (busy === 1'b1 && n < 300) begin
            n++;
            if (done !== 1'b0) early_done = 1'b1;
            @(negedge clk);
        end
        chk($sformatf("v%0d busy_cycles", idx), 32'(n), 32'(v.busy_n));
        chk($sformatf("v%0d done_in_busy", idx), {31'd0, early_done}, 32'd0);
        chk($sformatf("v%0d done_pulse", idx), {31'd0, done}, {31'd0, v.busy_n > 0});
        chk($sformatf("v%0d hi", idx), hi, v.exp_hi);
        chk($sformatf("v%0d lo", idx), lo, v.exp_lo);
        @(negedge clk);
        chk($sformatf("v%0d done_drop", idx), {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        logic seen;

        vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[2]  = '{3'd3, 32'd7,         32'd0,        10, 32'd7,         32'hFFFF_FFFF};
        vecs[3]  = '{3'd4, 32'h1234_5678, 32'd0,        0,  32'h1234_5678, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[5]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0,        32'h8000_0000};
        vecs[6]  = '{3'd5, 32'hA5A5_A5A5, 32'd0,        0,  32'h0,         32'hA5A5_A5A5};
        vecs[7]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 10, 32'd1,        32'hFFFF_FFFD};
        vecs[8]  = '{3'd2, 32'hFFFF_FFF9, 32'd0,        10, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[9]  = '{3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 5, 32'hC000_0000, 32'h8000_0000};
        vecs[10] = '{3'd3, 32'hFFFF_FFFF, 32'd16,       10, 32'h0000_000F, 32'h0FFF_FFFF};
        vecs[11] = '{3'd4, 32'd0,         32'd0,        0,  32'h0,         32'h0FFF_FFFF};
        vecs[12] = '{3'd5, 32'hFFFF_FFFF, 32'd0,        0,  32'h0,         32'hFFFF_FFFF};
`ifdef MD_MADD_EN
        vecs[13] = '{3'd7, 32'd1,         32'd1,        5,  32'd1,         32'h0};
        vecs[14] = '{3'd6, 32'hFFFF_FFFF, 32'd1,        5,  32'h0,         32'hFFFF_FFFF};
`else
        vecs[13] = '{3'd7, 32'd1,         32'd1,        0,  32'h0,         32'hFFFF_FFFF};
        vecs[14] = '{3'd6, 32'hFFFF_FFFF, 32'd1,        0,  32'h0,         32'hFFFF_FFFF};
`endif

        reset  = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 3'd0;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);
        // State here: hi=0, lo=FFFFFFFF.

        // start while busy (even MTHI) is ignored and latency is unchanged.
        issue(3'd3, 32'd100, 32'd7);
        n = 1;
        @(negedge clk);
        if (busy === 1'b1) n++;
        start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        while (busy === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("busy_start busy_cycles", 32'(n), 32'd10);
        chk("busy_start done", {31'd0, done}, 32'd1);
        chk("busy_start hi", hi, 32'd2);
        chk("busy_start lo", lo, 32'd14);

        // cancel on busy cycle 4 of a DIV.
        issue(3'd2, 32'd100, 32'd3);
        repeat (3) @(negedge clk);
        chk("cancel busy_c4", {31'd0, busy}, 32'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel busy", {31'd0, busy}, 32'd0);
        seen = done;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        chk("cancel no_done", {31'd0, seen}, 32'd0);
        chk("cancel hi", hi, 32'd2);
        chk("cancel lo", lo, 32'd14);

        // start together with cancel in IDLE: nothing issues.
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 3'd4; a = 32'h77;
        @(negedge clk);
        chk("idle_cancel mthi hi", hi, 32'd2);
        op = 3'd0; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("idle_cancel mult busy", {31'd0, busy}, 32'd0);

        // cancel coinciding with the completing edge wins.
        issue(3'd0, 32'd5, 32'd5);
        repeat (4) @(negedge clk);
        chk("cancel_last busy_c5", {31'd0, busy}, 32'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_last busy", {31'd0, busy}, 32'd0);
        chk("cancel_last done", {31'd0, done}, 32'd0);
        chk("cancel_last lo", lo, 32'd14);
        @(negedge clk);
        chk("cancel_last done2", {31'd0, done}, 32'd0);

        // asynchronous reset on busy cycle 3 of a MULT.
        issue(3'd0, 32'd3, 32'd3);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_reset hi", hi, 32'd0);
        chk("mid_reset lo", lo, 32'd0);
        chk("mid_reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        chk("mid_reset quiet", {31'd0, seen}, 32'd0);
        chk("mid_reset lo_after", lo, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end

endmodule

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
- Parametrised multi-cycle multiply/divide unit for the pipelined MIPS core. Sits beside the ALU in the E stage.
- Owns the HI/LO registers and models fixed multiply and divide latencies with a busy flag. The hazard unit uses busy to stall mfhi/mflo and further md instructions.
- Generalises the fixed 32-bit, fixed-latency unit: configurable width and latencies, cancel input, completion pulse.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu; legal range 1..255.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request issue of op this cycle.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU.
- a  input  WIDTH  operand rs.
- b  input  WIDTH  operand rt.
- cancel  input  1  abort the in-flight operation (exception flush).
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse when HI/LO take a multi-cycle result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, done=0, counter=0, state=IDLE.
- States: IDLE, RUN. Down-counter is 8 bits wide.
- IDLE with start=1 and op in {0,1,2,3,6,7} (6,7 only with the macro):
  - Full result is computed from a and b at the sampling edge and held in internal pending registers.
  - Counter loads MULT_CYCLES (ops 0,1,6,7) or DIV_CYCLES (ops 2,3).
  - State goes to RUN; busy=1 from the next cycle.
- RUN: counter decrements every cycle. On the edge where counter==1:
  - hi/lo take the pending values; done=1 for the following cycle.
  - busy=0 in that same following cycle; state returns to IDLE.
- Latency: busy is high for exactly N cycles; new hi/lo are visible on the cycle after the last busy cycle.
- MTHI/MTLO in IDLE with start: hi (or lo) <= a on the next edge. busy stays 0 and done stays 0.
- start while busy: ignored entirely, all ops. The stall logic must prevent this; the unit does not queue.
- start and cancel in the same IDLE cycle: cancel wins and nothing issues.
- cancel in RUN: state returns to IDLE on the next edge, busy=0, hi/lo unchanged, no done pulse.
  - If cancel coincides with the completing edge, cancel wins.
- Arithmetic:
  - MULT: signed 2*WIDTH product; hi=upper half, lo=lower half. MULTU: unsigned.
  - DIV: signed, truncating toward zero. lo=quotient, hi=remainder; remainder takes the sign of the dividend. DIVU: unsigned.
  - Divide by zero: lo = all ones, hi = a. Holds for signed and unsigned.
  - Signed overflow (a = most negative value, b = -1): lo=a, hi=0.
- Reset asserted mid-RUN: immediate return to reset values; pending result discarded.

Optional Feature:
- Macro MD_MADD_EN.
- Defined: op 6 (MADD) computes {hi,lo} + signed(a*b) and op 7 (MADDU) computes {hi,lo} + unsigned(a*b).
  - Addition is modulo 2^(2*WIDTH).
  - Uses the hi/lo values at issue time and MULT_CYCLES latency.
- Not defined: ops 6 and 7 are no-ops. No busy, no state change.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse for 1 cycle.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy high 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
- MTHI a=0x12345678 -> hi=0x12345678 on the next cycle, busy never asserts. Then MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Issue DIV, assert cancel on busy cycle 4 -> busy=0 on the next cycle, hi/lo keep prior values, no done. Also start on busy cycle 2 -> ignored and latency unchanged.
- Reset low on busy cycle 3 of MULT -> hi=lo=0, busy=0 immediately. Also DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- With MD_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 -> hi=1, lo=0. Without the macro, same stimulus -> busy stays 0, hi/lo unchanged.
